pc_ctrl: RTL and testbench
==========================

PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 32, address/PC width.
- RESET_VECTOR, 0, first fetch address after reset.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- pc  input  WIDTH  current value from the program counter register.
- pc_next  output  WIDTH  next PC value driven to the PC register.
- pc_en  output  1  enable to the PC register.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  WIDTH  fetch address.
- imem_ack  input  1  fetch complete; instruction data valid.
- instr_valid  output  1  fetched instruction is architecturally valid.
- stall  input  1  decode/execute cannot accept a new instruction.
- redirect  input  1  branch/jump taken.
- redirect_pc  input  WIDTH  branch/jump target.
- trap  input  1  exception request.
- trap_vec  input  WIDTH  trap handler address.
- misaligned  output  1  one-cycle pulse on misaligned redirect target.

Function
REQ-003 The FSM SHALL have the states BOOT, FETCH and STALL.
REQ-004 In BOOT, pc_en SHALL be 1 and pc_next SHALL be RESET_VECTOR for exactly one cycle, followed by an unconditional move to FETCH.
REQ-005 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc; both SHALL be held stable until imem_ack.
REQ-006 On imem_ack with no pending event, instr_valid SHALL pulse 1 and pc_en SHALL be 1 with pc_next = pc + 4 (modulo 2^WIDTH; 0xFFFFFFFC wraps to 0).
REQ-007 Next-PC priority in any cycle SHALL be: trap > redirect > sequential.
- trap selects trap_vec.
- redirect selects redirect_pc.
- sequential selects pc + 4.
REQ-008 If trap or redirect is asserted in FETCH before imem_ack, the target SHALL be latched into a pending register; a later, higher-priority event overwrites it.
REQ-009 On imem_ack with an event pending, instr_valid SHALL be 0, pc_en SHALL be 1, pc_next SHALL equal the latched target, and the pending register SHALL clear.
REQ-010 If an event is asserted in the same cycle as imem_ack, it SHALL take effect that cycle, with instr_valid = 0.
REQ-011 If a redirect target has bits [1:0] != 0, misaligned SHALL pulse 1 and the target SHALL be replaced by trap_vec.
REQ-012 stall SHALL be sampled only when no fetch is outstanding, i.e. in the cycle after an ack or on entry to FETCH.
- If stall = 1: move to STALL, imem_req = 0, pc_en = 0.
- In STALL: return to FETCH on the first cycle with stall = 0.
REQ-013 A trap or redirect in STALL SHALL update the PC immediately (pc_en = 1, selected target) while the FSM remains in STALL until stall = 0.
REQ-014 pc_en SHALL be 0 in every cycle not covered by REQ-004, REQ-006, REQ-009, REQ-010 or REQ-013.
REQ-015 The block SHALL issue at most one outstanding fetch.

Reset
REQ-016 While rst = 1, all of the following SHALL hold at the next clock edge:
- state = BOOT;
- pending register cleared;
- imem_req = 0, instr_valid = 0, misaligned = 0, pc_en = 0, pc_next = RESET_VECTOR.
REQ-017 Reset asserted mid-fetch SHALL abandon the outstanding request; a late imem_ack SHALL be ignored outside FETCH.

Structure
REQ-018 The state enum, instruction size constant (4) and RESET_VECTOR default SHALL reside in the shared package pc_ctrl_pkg.
REQ-019 The next-PC priority select plus the misalignment check SHALL be one sub-module, pc_next_mux; FSM and pending register SHALL stay in pc_ctrl.

Verification
REQ-020 Reset release: rst 1->0, then ack every cycle -> BOOT loads pc = 0, then imem_addr 0x0, 0x4, 0x8 with instr_valid = 1 on each ack.
REQ-021 Redirect during wait: fetch at 0x10, redirect = 1 with redirect_pc = 0x200 two cycles before the ack -> at the ack instr_valid = 0, pc_next = 0x200; the next imem_addr is 0x200.
REQ-022 Simultaneous events: trap (trap_vec = 0x100) and redirect (0x300) asserted in the same cycle as the ack -> pc_next = 0x100, instr_valid = 0.
REQ-023 Misaligned redirect: redirect_pc = 0x202, trap_vec = 0x100 -> misaligned pulses for 1 cycle, pc_next = 0x100.
REQ-024 Stall plus wrap: pc = 0xFFFFFFFC, ack, then stall held for 3 cycles -> pc_next = 0x0, imem_req = 0 for 3 cycles, and the fetch at 0x0 starts on the first cycle with stall low.
REQ-025 Reset mid-fetch: rst pulsed while imem_req = 1, ack arrives in BOOT -> ack ignored, and the fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the PC control block.
//   pc_state_e         : fetch FSM state encoding
//   InstrBytes         : size of one instruction, used for sequential PC advance
//   ResetVectorDefault : default first fetch address after reset
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StStall
    } pc_state_e;

    localparam int unsigned InstrBytes         = 4;
    localparam logic [31:0] ResetVectorDefault = 32'h0000_0000;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select with misaligned-redirect detection.
// Ports:
//   pc          : current PC
//   trap        : exception request, highest priority
//   trap_vec    : trap handler address
//   redirect    : branch/jump taken
//   redirect_pc : branch/jump target
//   target      : selected next PC (trap > redirect > pc + 4)
//   pc_seq      : sequential next PC, pc + 4 modulo 2^WIDTH
//   event_valid : trap or redirect present this cycle
//   event_trap  : the selected event is a trap (priority level of the event)
//   misaligned  : redirect selected and its target is not word aligned
module pc_next_mux
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic             trap,
    input  logic [WIDTH-1:0] trap_vec,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc_seq,
    output logic             event_valid,
    output logic             event_trap,
    output logic             misaligned
);

    logic redirect_bad;

    always_comb begin
        pc_seq       = pc + WIDTH'(InstrBytes);
        redirect_bad = (redirect_pc[1:0] != 2'b00);
        event_valid  = trap | redirect;
        event_trap   = trap;
        misaligned   = 1'b0;
        target       = pc_seq;
        if (trap) begin
            target = trap_vec;
        end else if (redirect) begin
            // A misaligned branch target is diverted to the trap handler.
            misaligned = redirect_bad;
            target     = redirect_bad ? trap_vec : redirect_pc;
        end
    end

endmodule

// File: rtl/pc_ctrl.sv
// Program counter control: boot load, single-outstanding instruction fetch,
// stall handling and trap/redirect steering of the external PC register.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   pc           : current PC register value
//   pc_next      : value to load into the PC register
//   pc_en        : PC register load enable
//   imem_req     : fetch request, imem_addr : fetch address (= pc)
//   imem_ack     : fetch complete
//   instr_valid  : fetched instruction is architecturally valid
//   stall        : downstream cannot take a new instruction
//   redirect     : branch/jump taken, redirect_pc : its target
//   trap         : exception request, trap_vec : handler address
//   misaligned   : pulse on a misaligned redirect target
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(ResetVectorDefault)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next,
    output logic             pc_en,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    output logic             instr_valid,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             trap,
    input  logic [WIDTH-1:0] trap_vec,
    output logic             misaligned
);

    pc_state_e        state_q, state_d;
    logic             busy_q, busy_d;           // fetch issued, not yet acked
    logic             pend_valid_q, pend_valid_d;
    logic             pend_trap_q, pend_trap_d;
    logic [WIDTH-1:0] pend_pc_q, pend_pc_d;

    logic [WIDTH-1:0] mux_target;
    logic [WIDTH-1:0] mux_pc_seq;
    logic             mux_event;
    logic             mux_event_trap;
    logic             mux_misaligned;
    logic             take_now;

    pc_next_mux #(
        .WIDTH (WIDTH)
    ) u_pc_next_mux (
        .pc          (pc),
        .trap        (trap),
        .trap_vec    (trap_vec),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .target      (mux_target),
        .pc_seq      (mux_pc_seq),
        .event_valid (mux_event),
        .event_trap  (mux_event_trap),
        .misaligned  (mux_misaligned)
    );

    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        pend_valid_d = pend_valid_q;
        pend_trap_d  = pend_trap_q;
        pend_pc_d    = pend_pc_q;
        pc_en        = 1'b0;
        pc_next      = RESET_VECTOR;
        imem_req     = 1'b0;
        imem_addr    = pc;
        instr_valid  = 1'b0;
        misaligned   = 1'b0;
        // A new event wins over a pending one unless it is a redirect
        // arriving after a pending trap.
        take_now     = mux_event & (~pend_valid_q | mux_event_trap | ~pend_trap_q);

        unique case (state_q)
            StBoot: begin
                pc_en        = 1'b1;
                pc_next      = RESET_VECTOR;
                state_d      = StFetch;
                busy_d       = 1'b0;
                pend_valid_d = 1'b0;
            end
            StFetch, StStall: begin
                // stall only matters while no fetch is outstanding
                if (busy_q || !stall) begin
                    imem_req   = 1'b1;
                    state_d    = StFetch;
                    misaligned = mux_misaligned;
                    if (imem_ack) begin
                        pc_en        = 1'b1;
                        busy_d       = 1'b0;
                        pend_valid_d = 1'b0;
                        if (take_now) begin
                            pc_next = mux_target;
                        end else if (pend_valid_q) begin
                            pc_next = pend_pc_q;
                        end else begin
                            pc_next     = mux_pc_seq;
                            instr_valid = 1'b1;
                        end
                    end else begin
                        busy_d = 1'b1;
                        if (take_now) begin
                            pend_valid_d = 1'b1;
                            pend_trap_d  = mux_event_trap;
                            pend_pc_d    = mux_target;
                        end
                    end
                end else begin
                    state_d    = StStall;
                    misaligned = mux_misaligned;
                    if (mux_event) begin
                        pc_en   = 1'b1;
                        pc_next = mux_target;
                    end
                end
            end
            default: state_d = StBoot;
        endcase

        if (rst) begin
            pc_en       = 1'b0;
            pc_next     = RESET_VECTOR;
            imem_req    = 1'b0;
            instr_valid = 1'b0;
            misaligned  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StBoot;
            busy_q       <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_trap_q  <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            pend_valid_q <= pend_valid_d;
            pend_trap_q  <= pend_trap_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl. The bench owns the PC register.
module tb_pc_ctrl;

    typedef struct packed {
        logic        pc_en;
        logic [31:0] pc_next;
        logic        iv;
        logic        mis;
    } upd_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        trap;
    logic [31:0] trap_vec;
    logic        misaligned;

    upd_t        exp_upd[$];
    logic [31:0] exp_fetch[$];
    upd_t        mon_e;
    logic [31:0] mon_a;
    int          checks = 0;
    int          errors = 0;

    pc_ctrl #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .pc_next     (pc_next),
        .pc_en       (pc_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .trap        (trap),
        .trap_vec    (trap_vec),
        .misaligned  (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial pc = 32'hDEAD_BEE0;
    always @(posedge clk) if (pc_en) pc <= pc_next;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_upd(input logic [31:0] nxt, input logic iv, input logic mis);
        upd_t u;
        u.pc_en   = 1'b1;
        u.pc_next = nxt;
        u.iv      = iv;
        u.mis     = mis;
        exp_upd.push_back(u);
    endtask

    // Monitor: every PC update / valid / misaligned cycle and every acked fetch.
    always @(negedge clk) begin
        if (!rst) begin
            if (pc_en || instr_valid || misaligned) begin
                if (exp_upd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update: got pc_en=%b pc_next=%h iv=%b mis=%b expected none",
                             pc_en, pc_next, instr_valid, misaligned);
                end else begin
                    mon_e = exp_upd.pop_front();
                    check("upd_pc_en", {31'b0, pc_en}, {31'b0, mon_e.pc_en});
                    if (mon_e.pc_en) check("upd_pc_next", pc_next, mon_e.pc_next);
                    check("upd_instr_valid", {31'b0, instr_valid}, {31'b0, mon_e.iv});
                    check("upd_misaligned", {31'b0, misaligned}, {31'b0, mon_e.mis});
                end
            end
            if (imem_req && imem_ack) begin
                if (exp_fetch.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fetch: got addr %h expected none", imem_addr);
                end else begin
                    mon_a = exp_fetch.pop_front();
                    check("fetch_addr", imem_addr, mon_a);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
        redirect_pc = '0; trap = 1'b0; trap_vec = '0;
        repeat (3) step();
        // Reset: outputs quiet even with a stray ack.
        imem_ack = 1'b1;
        #1;
        check("rst_pc_en", {31'b0, pc_en}, 32'd0);
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_misaligned", {31'b0, misaligned}, 32'd0);
        check("rst_pc_next", pc_next, 32'h0);
        step();

        // Boot then sequential fetch with ack every cycle.
        rst = 1'b0;
        push_upd(32'h0, 1'b0, 1'b0);
        step();
        for (int i = 0; i < 4; i++) begin
            exp_fetch.push_back(32'(4 * i));
            push_upd(32'(4 * i + 4), 1'b1, 1'b0);
            step();
        end

        // Redirect two cycles before the ack of the fetch at 0x10.
        imem_ack = 1'b0;
        #1;
        check("wait_req", {31'b0, imem_req}, 32'd1);
        check("wait_addr", imem_addr, 32'h10);
        step();
        redirect = 1'b1; redirect_pc = 32'h200;
        #1;
        check("wait_addr_held", imem_addr, 32'h10);
        check("wait_no_pc_en", {31'b0, pc_en}, 32'd0);
        step();
        redirect = 1'b0;
        step();
        imem_ack = 1'b1;
        exp_fetch.push_back(32'h10);
        push_upd(32'h200, 1'b0, 1'b0);
        step();

        // Trap and redirect together with the ack: trap wins.
        trap = 1'b1; trap_vec = 32'h100; redirect = 1'b1; redirect_pc = 32'h300;
        exp_fetch.push_back(32'h200);
        push_upd(32'h100, 1'b0, 1'b0);
        step();

        // Misaligned redirect is diverted to trap_vec.
        trap = 1'b0; redirect_pc = 32'h202;
        exp_fetch.push_back(32'h100);
        push_upd(32'h100, 1'b0, 1'b1);
        step();

        // Trap to the top of memory, then wrap to 0.
        redirect = 1'b0; trap = 1'b1; trap_vec = 32'hFFFF_FFFC;
        exp_fetch.push_back(32'h100);
        push_upd(32'hFFFF_FFFC, 1'b0, 1'b0);
        step();
        trap = 1'b0;
        exp_fetch.push_back(32'hFFFF_FFFC);
        push_upd(32'h0, 1'b1, 1'b0);
        step();

        // Stall for three cycles, fetch at 0 on the first cycle with stall low.
        imem_ack = 1'b0; stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_no_req", {31'b0, imem_req}, 32'd0);
            step();
        end
        stall = 1'b0; imem_ack = 1'b1;
        exp_fetch.push_back(32'h0);
        push_upd(32'h4, 1'b1, 1'b0);
        #1;
        check("unstall_req", {31'b0, imem_req}, 32'd1);
        check("unstall_addr", imem_addr, 32'h0);
        step();

        // Redirect while stalled updates the PC at once.
        imem_ack = 1'b0; stall = 1'b1;
        step();
        redirect = 1'b1; redirect_pc = 32'h40;
        push_upd(32'h40, 1'b0, 1'b0);
        #1;
        check("stall_redir_no_req", {31'b0, imem_req}, 32'd0);
        step();
        redirect = 1'b0;
        #1;
        check("stall_hold_no_req", {31'b0, imem_req}, 32'd0);
        step();
        stall = 1'b0;
        #1;
        check("post_stall_addr", imem_addr, 32'h40);
        step();

        // Reset mid-fetch; the late ack lands in BOOT and is ignored.
        rst = 1'b1;
        #1;
        check("midrst_no_req", {31'b0, imem_req}, 32'd0);
        step();
        rst = 1'b0; imem_ack = 1'b1;
        push_upd(32'h0, 1'b0, 1'b0);
        step();
        exp_fetch.push_back(32'h0);
        push_upd(32'h4, 1'b1, 1'b0);
        step();

        // Pending: redirect, then trap overwrites, then a redirect does not.
        imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h80;
        step();
        redirect = 1'b0; trap = 1'b1; trap_vec = 32'h100;
        step();
        trap = 1'b0; redirect = 1'b1; redirect_pc = 32'h90;
        step();
        redirect = 1'b0; imem_ack = 1'b1;
        exp_fetch.push_back(32'h4);
        push_upd(32'h100, 1'b0, 1'b0);
        step();
        exp_fetch.push_back(32'h100);
        push_upd(32'h104, 1'b1, 1'b0);
        step();

        imem_ack = 1'b0; stall = 1'b1;
        step();
        step();
        check("upd_queue_empty", 32'(exp_upd.size()), 32'd0);
        check("fetch_queue_empty", 32'(exp_fetch.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
